bus_arbiter: RTL and testbench

//   Grant controller for the two-master serial system bus. Decides which master

---
 rtl/bus_arb_pkg.sv | 15 +
 rtl/arb_tenure_timer.sv | 37 +++
 rtl/bus_arbiter.sv | 126 ++++++++++++
 tb/tb_bus_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared state encoding and master ids for the bus arbiter
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN1 = 2'd1,
    OWN2 = 2'd2
  } arb_state_e;

  localparam logic MID_M1 = 1'b0;
  localparam logic MID_M2 = 1'b1;

  localparam int TO_W_DEFAULT = 8;

endpackage

// File: rtl/arb_tenure_timer.sv
// rtl/arb_tenure_timer.sv - per-tenure cycle counter with expire flag
module arb_tenure_timer
  import bus_arb_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = TO_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [TO_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Count reads 0 on the first owned cycle, so TIMEOUT-1 marks the last allowed one.
  assign expire = (TIMEOUT != 0) && (count_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master bus grant controller with split and tenure timeout
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter bit RR_EN    = 1'b0,
  parameter bit SPLIT_EN = 1'b1,
  parameter int TIMEOUT  = 255,
  parameter int TO_W     = TO_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic m1_breq,
  input  logic m2_breq,
  output logic m1_bgrant,
  output logic m2_bgrant,
  output logic m1_split,
  output logic m2_split,
  input  logic split_req,
  input  logic split_done,
  output logic split_grant,
  output logic bus_sel,
  output logic bus_busy,
  output logic timeout
);

  arb_state_e state_q, state_d;
  logic m1_split_q, m1_split_d, m2_split_q, m2_split_d;
  logic done_pend_q, done_pend_d, rr_last_q, rr_last_d;
  logic split_grant_q, split_grant_d, bus_sel_q, bus_sel_d, timeout_q, timeout_d;
  logic owning, owner, own_breq, any_split, elig1, elig2, pick_m2, expire;

  assign owning    = (state_q == OWN1) || (state_q == OWN2);
  assign owner     = (state_q == OWN2) ? MID_M2 : MID_M1;
  assign own_breq  = (owner == MID_M2) ? m2_breq : m1_breq;
  assign any_split = m1_split_q | m2_split_q;
  assign elig1     = m1_breq & ~m1_split_q;
  assign elig2     = m2_breq & ~m2_split_q;
  // On a tie fixed priority favours M1; round-robin favours whoever did not own last.
  assign pick_m2   = elig2 & (~elig1 | (RR_EN & (rr_last_q == MID_M1)));

  arb_tenure_timer #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (~owning),
    .en     (owning),
    .expire (expire)
  );

  always_comb begin
    state_d       = state_q;
    m1_split_d    = m1_split_q;
    m2_split_d    = m2_split_q;
    rr_last_d     = rr_last_q;
    split_grant_d = split_grant_q;
    bus_sel_d     = bus_sel_q;
    timeout_d     = 1'b0;
    done_pend_d   = done_pend_q | (SPLIT_EN & split_done & any_split);
    unique case (state_q)
      IDLE: begin
        if (SPLIT_EN && done_pend_q && any_split) begin
          state_d       = m1_split_q ? OWN1 : OWN2;
          bus_sel_d     = m1_split_q ? MID_M1 : MID_M2;
          m1_split_d    = 1'b0;
          m2_split_d    = 1'b0;
          done_pend_d   = 1'b0;
          split_grant_d = 1'b1;
        end else if (elig1 || elig2) begin
          state_d   = pick_m2 ? OWN2 : OWN1;
          bus_sel_d = pick_m2 ? MID_M2 : MID_M1;
        end
      end
      OWN1, OWN2: begin
        if (SPLIT_EN && split_req && !any_split) begin
          state_d = IDLE;
          if (owner == MID_M1) m1_split_d = 1'b1;
          else                 m2_split_d = 1'b1;
        end else if (!own_breq) begin
          state_d = IDLE;
        end else if (expire) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
        if (state_d == IDLE) begin
          rr_last_d     = owner;
          split_grant_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      m1_split_q    <= 1'b0;
      m2_split_q    <= 1'b0;
      done_pend_q   <= 1'b0;
      rr_last_q     <= MID_M1;
      split_grant_q <= 1'b0;
      bus_sel_q     <= MID_M1;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      m1_split_q    <= m1_split_d;
      m2_split_q    <= m2_split_d;
      done_pend_q   <= done_pend_d;
      rr_last_q     <= rr_last_d;
      split_grant_q <= split_grant_d;
      bus_sel_q     <= bus_sel_d;
      timeout_q     <= timeout_d;
    end
  end

  assign m1_bgrant   = (state_q == OWN1);
  assign m2_bgrant   = (state_q == OWN2);
  assign m1_split    = m1_split_q;
  assign m2_split    = m2_split_q;
  assign split_grant = split_grant_q;
  assign bus_sel     = bus_sel_q;
  assign bus_busy    = m1_bgrant | m2_bgrant;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - fixed-priority and round-robin arbiters against a tenure-level model
module tb_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, m1_breq, m2_breq, split_req, split_done;
  wire [1:0] o_g1, o_g2, o_s1, o_s2, o_sg, o_sel, o_busy, o_to;

  bus_arbiter #(.RR_EN(1'b0), .SPLIT_EN(1'b1), .TIMEOUT(4), .TO_W(8)) dut_fp (
    .clk(clk), .rst(rst), .m1_breq(m1_breq), .m2_breq(m2_breq),
    .m1_bgrant(o_g1[0]), .m2_bgrant(o_g2[0]), .m1_split(o_s1[0]), .m2_split(o_s2[0]),
    .split_req(split_req), .split_done(split_done), .split_grant(o_sg[0]),
    .bus_sel(o_sel[0]), .bus_busy(o_busy[0]), .timeout(o_to[0])
  );

  bus_arbiter #(.RR_EN(1'b1), .SPLIT_EN(1'b1), .TIMEOUT(6), .TO_W(8)) dut_rr (
    .clk(clk), .rst(rst), .m1_breq(m1_breq), .m2_breq(m2_breq),
    .m1_bgrant(o_g1[1]), .m2_bgrant(o_g2[1]), .m1_split(o_s1[1]), .m2_split(o_s2[1]),
    .split_req(split_req), .split_done(split_done), .split_grant(o_sg[1]),
    .bus_sel(o_sel[1]), .bus_busy(o_busy[1]), .timeout(o_to[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: owner as 0/1/2, tenure length in owned cycles, parked masters by number.
  int own[2], last[2], sel[2], ten[2];
  bit parked[2][1:2];
  bit pend[2], sg[2], to_p[2];
  int tmo[2] = '{4, 6};
  bit rr[2]  = '{1'b0, 1'b1};

  task automatic model_reset(input int k);
    own[k] = 0; last[k] = 1; sel[k] = 1; ten[k] = 0;
    parked[k][1] = 1'b0; parked[k][2] = 1'b0;
    pend[k] = 1'b0; sg[k] = 1'b0; to_p[k] = 1'b0;
  endtask

  task automatic model_step(input int k);
    bit pend_old, anyp, e1, e2, leave, req;
    int m;
    m        = 0;
    pend_old = pend[k];
    anyp     = parked[k][1] | parked[k][2];
    to_p[k]  = 1'b0;
    if (split_done && anyp) pend[k] = 1'b1;
    if (own[k] == 0) begin
      if (pend_old && anyp) begin
        m = parked[k][1] ? 1 : 2;
        parked[k][m] = 1'b0;
        pend[k] = 1'b0;
        sg[k] = 1'b1;
      end else begin
        e1 = m1_breq && !parked[k][1];
        e2 = m2_breq && !parked[k][2];
        if (e1 && e2) m = (rr[k] && last[k] == 1) ? 2 : 1;
        else          m = e1 ? 1 : (e2 ? 2 : 0);
      end
      if (m != 0) begin
        own[k] = m; sel[k] = m; ten[k] = 1;
      end
    end else begin
      m     = own[k];
      req   = (m == 1) ? m1_breq : m2_breq;
      leave = 1'b1;
      if (split_req && !anyp) parked[k][m] = 1'b1;
      else if (!req) leave = 1'b1;
      else if (tmo[k] != 0 && ten[k] == tmo[k]) to_p[k] = 1'b1;
      else begin
        leave = 1'b0;
        ten[k]++;
      end
      if (leave) begin
        own[k] = 0; last[k] = m; sg[k] = 1'b0;
      end
    end
  endtask

  function automatic logic [7:0] model_vec(input int k);
    return {own[k] == 1, own[k] == 2, parked[k][1], parked[k][2],
            sg[k], sel[k] == 2, own[k] != 0, to_p[k]};
  endfunction

  function automatic logic [7:0] dut_vec(input int k);
    return {o_g1[k], o_g2[k], o_s1[k], o_s2[k], o_sg[k], o_sel[k], o_busy[k], o_to[k]};
  endfunction

  task automatic cycle();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) model_reset(k);
      else     model_step(k);
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) check($sformatf("outputs[%0d]", k), dut_vec(k), model_vec(k));
    check("mutex", o_g1 & o_g2, 0);
  endtask

  initial begin
    rst = 1'b1; m1_breq = 1'b0; m2_breq = 1'b0; split_req = 1'b0; split_done = 1'b0;
    cycle(); cycle();
    check("reset_fp", dut_vec(0), 0);
    check("reset_rr", dut_vec(1), 0);
    rst = 1'b0;

    m1_breq = 1'b1; cycle();
    check("t1_grant", {o_g1[0], o_sel[0]}, 2'b10);
    m1_breq = 1'b0; cycle();
    check("t1_release", o_g1[0], 0);

    m1_breq = 1'b1; m2_breq = 1'b1; cycle();
    check("t2_fixed_m1", {o_g1[0], o_g2[0]}, 2'b10);
    check("t3_rr_m2", {o_g1[1], o_g2[1]}, 2'b01);
    m1_breq = 1'b0; cycle();
    check("t2_turnaround", o_busy[0], 0);
    cycle();
    check("t2_m2", {o_g2[0], o_sel[0]}, 2'b11);
    m2_breq = 1'b0; cycle(); cycle();

    m1_breq = 1'b1; cycle();
    m2_breq = 1'b1; split_req = 1'b1; cycle(); split_req = 1'b0;
    check("t4_split", {o_g1[0], o_s1[0]}, 2'b01);
    cycle();
    check("t4_m2", o_g2[0], 1);
    split_done = 1'b1; cycle(); split_done = 1'b0;
    m2_breq = 1'b0; cycle();
    cycle();
    check("t4_regrant", {o_g1[0], o_sg[0], o_s1[0]}, 3'b110);
    m1_breq = 1'b0; cycle(); cycle();

    m2_breq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check($sformatf("t5_hold%0d", i), o_g2[0], 1);
    end
    cycle();
    check("t5_timeout", {o_g2[0], o_to[0]}, 2'b01);
    cycle();
    check("t5_regrant", {o_g2[0], o_to[0]}, 2'b10);

    m2_breq = 1'b0; cycle();
    m1_breq = 1'b1; cycle();
    check("t6_m1", o_g1[0], 1);
    m2_breq = 1'b1; split_req = 1'b1; cycle(); split_req = 1'b0;
    cycle();
    check("t6_own2", {o_g2[0], o_s1[0]}, 2'b11);
    rst = 1'b1; cycle();
    check("t6_reset", dut_vec(0), 0);
    rst = 1'b0; m1_breq = 1'b0; m2_breq = 1'b0; cycle();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) m1_breq = ~m1_breq;
      if ($urandom_range(7) == 0) m2_breq = ~m2_breq;
      split_req  = ($urandom_range(9) == 0);
      split_done = ($urandom_range(7) == 0);
      rst        = ($urandom_range(299) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
